mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Multiply/divide unit in the EX stage, directly downstream of instruction decode.
- Consumes the decoder's 4-bit MDU opcode plus the rs/rt operand values.
- Owns the HI/LO registers and runs MULT/MULTU (pipelined, fixed latency) and DIV/DIVU (iterative, 32 cycles).
- Returns GPR results for MUL, MFHI and MFLO, and stalls the pipeline when a result or the unit is not ready.

Parameters:
- MUL_CYCLES, 2, number of cycles in MUL_WAIT (legal range 1..8).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- mdu_en_i  input  1  EX-stage instruction is valid (not a bubble).
- mdu_op_i  input  4  opcode: 0 none, 1 DIV, 2 DIVU, 3 MUL, 4 MULT, 5 MULTU, 6 MFHI, 7 MFLO, 8 MTHI, 9 MTLO; 10-15 treated as 0.
- mdu_a_i  input  32  rs value (dividend / multiplicand / MTHI-MTLO source).
- mdu_b_i  input  32  rt value (divisor / multiplier).
- mdu_stall_o  output  1  combinational; hold EX and all earlier stages.
- mdu_result_o  output  32  combinational GPR result: MFHI→HI, MFLO→LO, MUL→mul_lo_r, otherwise 0.
- mdu_busy_o  output  1  state != IDLE.
- hi_o  output  32  HI register.
- lo_o  output  32  LO register.

Behaviour:
- Reset: state IDLE; HI, LO, mul_lo_r, mul_done_r, operand latches and divider registers all 0; stall_o=0, busy_o=0, result_o=0.
- "Issue" means mdu_en_i=1 and op in 1..9.
- States: IDLE, MUL_WAIT, DIV_RUN, DIV_FIX.
- IDLE, op MULT/MULTU/DIV/DIVU issued:
  - Latch a, b and op.
  - Go to MUL_WAIT (count=MUL_CYCLES-1) or DIV_RUN (count=31).
  - stall_o=0; the instruction retires.
- IDLE, op MUL issued with mul_done_r=0:
  - Latch operands, go to MUL_WAIT, stall_o=1.
  - Pipeline holds op and operands stable while stalled.
- IDLE, op MUL with mul_done_r=1: stall_o=0, result_o=mul_lo_r; mul_done_r clears at this edge.
- IDLE, op MTHI/MTLO: HI (or LO) ← a at this edge; no stall.
- IDLE, op MFHI/MFLO: result_o = current HI/LO; no stall.
- State != IDLE and any issue (op 1..9): stall_o=1.
- mdu_en_i=0: no action, stall_o=0.
- MUL_WAIT:
  - Decrement count; the product is computed over these cycles.
  - Last cycle (count=0), MULT: {HI,LO} ← signed 64-bit product.
  - Last cycle, MULTU: {HI,LO} ← unsigned 64-bit product.
  - Last cycle, MUL: mul_lo_r ← low 32 bits, mul_done_r ← 1; HI/LO unchanged.
  - Then → IDLE.
- DIV_RUN:
  - Radix-2 restoring division on magnitudes (signed ops take |a|, |b|), one quotient bit per cycle, 32 cycles.
  - Then → DIV_FIX.
- DIV_FIX, sign fixup for DIV only:
  - Quotient negated iff operand signs differ.
  - Remainder takes the sign of the dividend.
  - LO ← quotient, HI ← remainder.
  - Then → IDLE.
- Divide by zero (either op): no exception; LO=0xFFFFFFFF, HI=a (raw dividend).
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Timing, for an issue edge at the end of cycle T:
  - MULT: HI/LO written at the end of T+MUL_CYCLES; IDLE at T+MUL_CYCLES+1.
  - DIV: DIV_RUN T+1..T+32, DIV_FIX T+33, IDLE at T+34.
  - MFHI/MFLO at T+34 returns the new value with no stall.
  - MUL: stall_o=1 for cycles T..T+MUL_CYCLES; the result is presented unstalled at T+MUL_CYCLES+1.
- In-flight operations always complete; there is no flush.
- Reset mid-operation abandons the operation and clears HI/LO.
- Operand inputs are sampled only at issue; later changes have no effect.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5, then MFLO next cycle → stall_o high for MUL_CYCLES cycles, then result_o=0xFFFFFFF1 and hi_o=0xFFFFFFFF.
- MULTU a=0xFFFFFFFF, b=2 → HI=0x00000001, LO=0xFFFFFFFE at the end of T+MUL_CYCLES; busy_o deasserts at T+MUL_CYCLES+1.
- DIV a=0xFFFFFFF9 (-7), b=2, then MFHI held → stall for exactly 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; also DIVU 100/7 → LO=14, HI=2.
- DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0; DIVU 0x1234/0 → LO=0xFFFFFFFF, HI=0x1234.
- MUL a=6, b=7, held with mdu_en_i=1 → stall_o=1 for 1+MUL_CYCLES cycles, then one unstalled cycle with result_o=42; HI/LO unchanged (preload via MTHI/MTLO to 0xA5A5A5A5).
- DIVU started, rst pulsed at T+10 → state IDLE, HI=LO=0, busy_o=0 immediately (asynchronous); a following MFLO returns 0 with no stall.

Source files
------------

// File: rtl/mdu_unit.sv
// EX-stage multiply/divide unit owning HI/LO.
// Pipelined MULT/MULTU/MUL with fixed latency; radix-2 restoring DIV/DIVU.
module mdu_unit #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdu_en_i,
    input  logic [3:0]  mdu_op_i,
    input  logic [31:0] mdu_a_i,
    input  logic [31:0] mdu_b_i,
    output logic        mdu_stall_o,
    output logic [31:0] mdu_result_o,
    output logic        mdu_busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE,
        MUL_WAIT,
        DIV_RUN,
        DIV_FIX
    } state_t;

    localparam logic [3:0] OP_DIV   = 4'd1;
    localparam logic [3:0] OP_DIVU  = 4'd2;
    localparam logic [3:0] OP_MUL   = 4'd3;
    localparam logic [3:0] OP_MULT  = 4'd4;
    localparam logic [3:0] OP_MULTU = 4'd5;
    localparam logic [3:0] OP_MFHI  = 4'd6;
    localparam logic [3:0] OP_MFLO  = 4'd7;
    localparam logic [3:0] OP_MTHI  = 4'd8;
    localparam logic [3:0] OP_MTLO  = 4'd9;

    localparam logic [4:0] MUL_CNT = 5'(MUL_CYCLES - 1);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] mul_lo_q, mul_lo_d;
    logic        mul_done_q, mul_done_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;

    logic        issue;
    logic [31:0] a_mag, b_mag;
    logic [63:0] mul_x, mul_y, prod;
    logic [32:0] shifted, diff;
    logic [31:0] quo_fix, rem_fix;

    assign issue = mdu_en_i && (mdu_op_i >= OP_DIV) && (mdu_op_i <= OP_MTLO);

    // Signed divide runs on magnitudes; sign is restored in DIV_FIX.
    assign a_mag = (mdu_op_i == OP_DIV && mdu_a_i[31]) ? -mdu_a_i : mdu_a_i;
    assign b_mag = (mdu_op_i == OP_DIV && mdu_b_i[31]) ? -mdu_b_i : mdu_b_i;

    assign mul_x = (op_q == OP_MULT) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    assign mul_y = (op_q == OP_MULT) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    assign prod  = mul_x * mul_y;

    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dvs_q};

    assign quo_fix = (op_q == OP_DIV && (a_q[31] ^ b_q[31])) ? -quo_q : quo_q;
    assign rem_fix = (op_q == OP_DIV && a_q[31]) ? -rem_q : rem_q;

    assign mdu_busy_o = (state_q != IDLE);
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

    always_comb begin
        mdu_result_o = 32'd0;
        if (mdu_en_i) begin
            case (mdu_op_i)
                OP_MFHI: mdu_result_o = hi_q;
                OP_MFLO: mdu_result_o = lo_q;
                OP_MUL:  mdu_result_o = mul_lo_q;
                default: mdu_result_o = 32'd0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        mul_lo_d    = mul_lo_q;
        mul_done_d  = mul_done_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        mdu_stall_o = issue && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (issue) begin
                    case (mdu_op_i)
                        OP_DIV, OP_DIVU: begin
                            op_d    = mdu_op_i;
                            a_d     = mdu_a_i;
                            b_d     = mdu_b_i;
                            rem_d   = 32'd0;
                            quo_d   = a_mag;
                            dvs_d   = b_mag;
                            cnt_d   = 5'd31;
                            state_d = DIV_RUN;
                        end
                        OP_MULT, OP_MULTU: begin
                            op_d    = mdu_op_i;
                            a_d     = mdu_a_i;
                            b_d     = mdu_b_i;
                            cnt_d   = MUL_CNT;
                            state_d = MUL_WAIT;
                        end
                        OP_MUL: begin
                            if (mul_done_q) begin
                                mul_done_d = 1'b0;
                            end else begin
                                op_d        = mdu_op_i;
                                a_d         = mdu_a_i;
                                b_d         = mdu_b_i;
                                cnt_d       = MUL_CNT;
                                state_d     = MUL_WAIT;
                                mdu_stall_o = 1'b1;
                            end
                        end
                        OP_MTHI: hi_d = mdu_a_i;
                        OP_MTLO: lo_d = mdu_a_i;
                        default: ;
                    endcase
                end
            end
            MUL_WAIT: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = IDLE;
                    if (op_q == OP_MUL) begin
                        mul_lo_d   = prod[31:0];
                        mul_done_d = 1'b1;
                    end else begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end
                end
            end
            DIV_RUN: begin
                cnt_d = cnt_q - 5'd1;
                if (!diff[32]) begin
                    rem_d = diff[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = shifted[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                if (cnt_q == 5'd0) begin
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                state_d = IDLE;
                if (b_q == 32'd0) begin
                    lo_d = 32'hFFFF_FFFF;
                    hi_d = a_q;
                end else begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            op_q       <= 4'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            mul_lo_q   <= 32'd0;
            mul_done_q <= 1'b0;
            rem_q      <= 32'd0;
            quo_q      <= 32'd0;
            dvs_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            mul_lo_q   <= mul_lo_d;
            mul_done_q <= mul_done_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboarded bench for mdu_unit: directed corner cases plus random ops
// checked against an arithmetic HI/LO reference model.
module tb_mdu_unit;

    localparam int MC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        stall, busy;
    logic [31:0] result, hi, lo;

    int errs = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_hi, m_lo;
    int s;

    mdu_unit #(.MUL_CYCLES(MC)) dut (
        .clk          (clk),
        .rst          (rst),
        .mdu_en_i     (en),
        .mdu_op_i     (op),
        .mdu_a_i      (a),
        .mdu_b_i      (b),
        .mdu_stall_o  (stall),
        .mdu_result_o (result),
        .mdu_busy_o   (busy),
        .hi_o         (hi),
        .lo_o         (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural model: HI/LO updated in program order at issue time.
    function automatic logic [31:0] model(input logic [3:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        logic [31:0] r;
        logic [63:0] p;
        longint sp;
        r = 32'd0;
        case (o)
            4'd1: begin
                if (y == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = x;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = 32'd0;
                end else begin
                    m_lo = $signed(x) / $signed(y);
                    m_hi = $signed(x) % $signed(y);
                end
            end
            4'd2: begin
                if (y == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = x;
                end else begin
                    m_lo = x / y;
                    m_hi = x % y;
                end
            end
            4'd3: r = x * y;
            4'd4: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                p = sp;
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            4'd5: begin
                p = {32'd0, x} * {32'd0, y};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            4'd6: r = m_hi;
            4'd7: r = m_lo;
            4'd8: m_hi = x;
            4'd9: m_lo = x;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Present one instruction; hold it until the unit accepts it.
    task automatic do_op(input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, output int stalls);
        bit done;
        en = 1'b1;
        op = o;
        a  = x;
        b  = y;
        exp_q.push_back(model(o, x, y));
        stalls = 0;
        do begin
            @(negedge clk);
            done = !stall;
            if (!done) stalls++;
        end while (!done && stalls < 200);
        if (!done) begin
            checks++;
            errs++;
            $display("FAIL stall_timeout: op %0d still stalled after %0d",
                     o, stalls);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        op = 4'($urandom);
        a  = $urandom;
        b  = $urandom;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(1, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every accepted instruction yields one result to compare.
    always @(negedge clk) begin
        if (!rst && en && !stall) begin
            if (exp_q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL result_unexpected: got %h expected none",
                         result);
            end else begin
                chk("result", result, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        op  = 4'd0;
        a   = 32'd0;
        b   = 32'd0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        do_op(4'd4, 32'hFFFF_FFFD, 32'd5, s);
        chk("mult_stall", s, 0);
        do_op(4'd7, 32'd0, 32'd0, s);
        chk("mflo_after_mult_stall", s, MC);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);

        do_op(4'd5, 32'hFFFF_FFFF, 32'd2, s);
        idle(0);
        for (int k = 1; k <= MC; k++) begin
            @(negedge clk);
            chk("multu_busy", {31'd0, busy}, 32'd1);
        end
        chk("multu_hi_old", hi, 32'hFFFF_FFFF);
        chk("multu_lo_old", lo, 32'hFFFF_FFF1);
        @(negedge clk);
        chk("multu_busy_done", {31'd0, busy}, 32'd0);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);
        @(posedge clk);
        #1;

        do_op(4'd1, 32'hFFFF_FFF9, 32'd2, s);
        do_op(4'd6, 32'd0, 32'd0, s);
        chk("div_mfhi_stall", s, 33);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        do_op(4'd2, 32'd100, 32'd7, s);
        do_op(4'd7, 32'd0, 32'd0, s);
        chk("divu_mflo_stall", s, 33);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        do_op(4'd1, 32'h8000_0000, 32'hFFFF_FFFF, s);
        do_op(4'd7, 32'd0, 32'd0, s);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'd0);
        do_op(4'd2, 32'h0000_1234, 32'd0, s);
        do_op(4'd6, 32'd0, 32'd0, s);
        chk("divz_lo", lo, 32'hFFFF_FFFF);
        chk("divz_hi", hi, 32'h0000_1234);
        do_op(4'd1, 32'hFFFF_FF00, 32'd0, s);
        do_op(4'd7, 32'd0, 32'd0, s);
        chk("sdivz_lo", lo, 32'hFFFF_FFFF);
        chk("sdivz_hi", hi, 32'hFFFF_FF00);

        do_op(4'd8, 32'hA5A5_A5A5, 32'd0, s);
        do_op(4'd9, 32'hA5A5_A5A5, 32'd0, s);
        do_op(4'd3, 32'd6, 32'd7, s);
        chk("mul_stall", s, 1 + MC);
        chk("mul_hi_kept", hi, 32'hA5A5_A5A5);
        chk("mul_lo_kept", lo, 32'hA5A5_A5A5);
        idle(1);

        do_op(4'd2, 32'h0000_DEAD, 32'd3, s);
        idle(9);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        #1;
        rst = 1'b0;
        idle(1);
        do_op(4'd7, 32'd0, 32'd0, s);
        chk("mflo_after_rst_stall", s, 0);

        for (int i = 0; i < 300; i++) begin
            do_op(4'($urandom_range(0, 15)), pick(), pick(), s);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        do_op(4'd6, 32'd0, 32'd0, s);
        do_op(4'd7, 32'd0, 32'd0, s);
        idle(3);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
